// File: rtl/avl_stream2dvp_tx.sv
// avl_stream2dvp_tx: replays 64-bit DDR words as DVP video timing.
// Ports:
//   clk_sys, reset        clock, sync active-high reset
//   enable                start frames / keep streaming
//   data_ddr, valid_data_ddr, ready_ddr  word handshake from DDR reader
//   VSYNC, HREF, D        DVP timing and pixel byte (D=0 outside HREF)
//   SOF, EOF              first byte of frame, last byte of each line
//   underflow             sticky starvation flag, cleared at VS entry
//   count_frame           frames started (wraps)
//   count_href            lines started in current frame
module avl_stream2dvp_tx #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int H_BLANK    = 144,
    parameter int VS_CYCLES  = 3000,
    parameter int VBP_CYCLES = 2000,
    parameter int VFP_CYCLES = 1000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] data_ddr,
    input  logic        valid_data_ddr,
    output logic        ready_ddr,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  D,
    output logic        SOF,
    output logic        EOF,
    output logic        underflow,
    output logic [7:0]  count_frame,
    output logic [9:0]  count_href
);

    localparam int M1 = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int M2 = (VS_CYCLES > VBP_CYCLES) ? VS_CYCLES : VBP_CYCLES;
    localparam int M3 = (M1 > M2) ? M1 : M2;
    localparam int CMAX = (M3 > VFP_CYCLES) ? M3 : VFP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VS, S_VBP, S_ACT, S_HBL, S_VFP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;

    logic [63:0] r_cur;
    logic [63:0] r_nxt;
    logic        r_cur_valid;
    logic        r_nxt_valid;
    logic [2:0]  r_idx;
    logic        r_ready;
    logic        r_vsync;
    logic        r_href;
    logic [7:0]  r_d;
    logic        r_sof;
    logic        r_eof;
    logic        r_unf;
    logic [7:0]  r_cf;
    logic [9:0]  r_ch;

    logic        w_vs_entry;
    logic        w_act_entry;
    logic        w_emit;
    logic        w_consume;
    logic        w_retire;
    logic        w_accept;
    logic [7:0]  w_byte;
    logic [63:0] w_cur_d;
    logic [63:0] w_nxt_d;
    logic        w_cur_valid_d;
    logic        w_nxt_valid_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (enable) w_state_nxt = S_VS;
            S_VS: if (r_cnt == CW'(VS_CYCLES - 1))
                w_state_nxt = S_VBP;
            S_VBP: if (r_cnt == CW'(VBP_CYCLES - 1))
                w_state_nxt = S_ACT;
            S_ACT: if (r_cnt == CW'(H_ACTIVE - 1))
                w_state_nxt = S_HBL;
            S_HBL: if (r_cnt == CW'(H_BLANK - 1))
                w_state_nxt = (r_ch == 10'(V_ACTIVE)) ? S_VFP : S_ACT;
            S_VFP: if (r_cnt == CW'(VFP_CYCLES - 1))
                w_state_nxt = enable ? S_VS : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != r_state || r_state == S_IDLE)
            w_cnt_d = '0;
        else
            w_cnt_d = r_cnt + 1'b1;
    end

    assign w_vs_entry  = (w_state_nxt == S_VS) && (r_state != S_VS);
    assign w_act_entry = (w_state_nxt == S_ACT) && (r_state != S_ACT);
    assign w_emit      = (w_state_nxt == S_ACT);
    assign w_consume   = w_emit && r_cur_valid;
    assign w_accept    = valid_data_ddr && r_ready;
    assign w_byte      = r_cur[{r_idx, 3'b000} +: 8];

    // A partially unpacked word is dropped at frame start so every
    // frame begins on a word boundary.
    assign w_retire = (w_consume && r_idx == 3'd7)
                   || (w_vs_entry && r_idx != 3'd0);

    always_comb begin
        w_cur_d       = r_cur;
        w_nxt_d       = r_nxt;
        w_cur_valid_d = r_cur_valid;
        w_nxt_valid_d = r_nxt_valid;
        if (!r_cur_valid || w_retire) begin
            if (r_nxt_valid) begin
                w_cur_d       = r_nxt;
                w_cur_valid_d = 1'b1;
                w_nxt_d       = data_ddr;
                w_nxt_valid_d = w_accept;
            end else begin
                w_cur_d       = data_ddr;
                w_cur_valid_d = w_accept;
            end
        end else if (w_accept) begin
            w_nxt_d       = data_ddr;
            w_nxt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cur       <= '0;
            r_nxt       <= '0;
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_idx       <= '0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_d         <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_unf       <= 1'b0;
            r_cf        <= '0;
            r_ch        <= '0;
        end else begin
            r_cur       <= w_cur_d;
            r_nxt       <= w_nxt_d;
            r_cur_valid <= w_cur_valid_d;
            r_nxt_valid <= w_nxt_valid_d;
            r_ready     <= !w_nxt_valid_d;
            if (w_vs_entry)
                r_idx <= '0;
            else if (w_consume)
                r_idx <= r_idx + 3'd1;
            r_vsync <= (w_state_nxt == S_VS);
            r_href  <= w_emit;
            r_d     <= w_consume ? w_byte : 8'h00;
            r_sof   <= w_act_entry && (r_ch == 10'd0);
            r_eof   <= w_emit && (w_cnt_d == CW'(H_ACTIVE - 1));
            if (w_vs_entry)
                r_unf <= 1'b0;
            else if (w_emit && !r_cur_valid)
                r_unf <= 1'b1;
            if (w_vs_entry)
                r_cf <= r_cf + 8'd1;
            if (w_vs_entry)
                r_ch <= '0;
            else if (w_act_entry)
                r_ch <= r_ch + 10'd1;
        end
    end

    assign ready_ddr   = r_ready;
    assign VSYNC       = r_vsync;
    assign HREF        = r_href;
    assign D           = r_d;
    assign SOF         = r_sof;
    assign EOF         = r_eof;
    assign underflow   = r_unf;
    assign count_frame = r_cf;
    assign count_href  = r_ch;

endmodule

// File: tb/tb_avl_stream2dvp_tx.sv
// tb_avl_stream2dvp_tx: scoreboard bench for avl_stream2dvp_tx.
// Frame-position model predicts timing; a word queue predicts bytes.
module tb_avl_stream2dvp_tx;

    localparam int HA   = 16;
    localparam int VA   = 2;
    localparam int HB   = 4;
    localparam int VSC  = 3;
    localparam int VBPC = 2;
    localparam int VFPC = 2;
    localparam int LN   = HA + HB;
    localparam int FL   = VSC + VBPC + VA * LN + VFPC;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        valid;
    logic [63:0] data;
    logic        ready_ddr;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  D;
    logic        SOF;
    logic        EOF;
    logic        underflow;
    logic [7:0]  count_frame;
    logic [9:0]  count_href;

    always #5 clk = ~clk;

    avl_stream2dvp_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VS_CYCLES(VSC), .VBP_CYCLES(VBPC), .VFP_CYCLES(VFPC)
    ) dut (
        .clk_sys(clk),
        .reset(reset),
        .enable(enable),
        .data_ddr(data),
        .valid_data_ddr(valid),
        .ready_ddr(ready_ddr),
        .VSYNC(VSYNC),
        .HREF(HREF),
        .D(D),
        .SOF(SOF),
        .EOF(EOF),
        .underflow(underflow),
        .count_frame(count_frame),
        .count_href(count_href)
    );

    typedef struct packed {
        logic       vs;
        logic       href;
        logic       sof;
        logic       eof;
        logic       unf;
        logic       rdy;
        logic [7:0] cf;
        logic [9:0] ch;
    } ctl_t;

    ctl_t       ctl_q[$];
    logic [7:0] byte_q[$];

    logic [63:0] m_words[$];
    int          m_idx = 0;
    bit          m_run = 0;
    int          m_p = 0;
    logic        m_unf = 1'b0;
    logic [7:0]  m_cf = 8'd0;
    logic [9:0]  m_ch = 10'd0;

    int checks = 0;
    int errors = 0;
    bit seq = 1;
    int wcnt = 0;

    function automatic logic [63:0] seqword(input int k);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++)
            w[8*i +: 8] = 8'(8 * k + i);
        return w;
    endfunction

    // One clock edge of the reference: frame position, byte pull,
    // then word push into a two-word store.
    task automatic model_step(
        input  logic        rst,
        input  logic        en,
        input  logic        vld,
        input  logic [63:0] dat,
        output bit          acc
    );
        bit          rdy;
        bit          vs_in;
        bit          act;
        int          off;
        int          l;
        int          c;
        logic [63:0] w;
        logic [7:0]  b;
        ctl_t        r;
        rdy = (m_words.size() < 2);
        acc = 0;
        r = '0;
        act = 0;
        l = 0;
        c = 0;
        if (rst) begin
            m_words.delete();
            m_idx = 0;
            m_run = 0;
            m_p = 0;
            m_unf = 1'b0;
            m_cf = 8'd0;
            m_ch = 10'd0;
        end else begin
            vs_in = 0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1;
                    m_p = 0;
                    vs_in = 1;
                end
            end else begin
                m_p++;
                if (m_p == FL) begin
                    if (en) begin
                        m_p = 0;
                        vs_in = 1;
                    end else begin
                        m_run = 0;
                    end
                end
            end
            if (vs_in) begin
                if (m_idx != 0) begin
                    void'(m_words.pop_front());
                    m_idx = 0;
                end
                m_unf = 1'b0;
                m_cf = m_cf + 8'd1;
                m_ch = 10'd0;
            end
            if (m_run) begin
                off = m_p - VSC - VBPC;
                if (off >= 0 && off < VA * LN) begin
                    l = off / LN;
                    c = off % LN;
                    act = (c < HA);
                end
            end
            if (act) begin
                if (c == 0)
                    m_ch = 10'(l + 1);
                b = 8'h00;
                if (m_words.size() > 0) begin
                    w = m_words[0];
                    b = 8'(w >> (8 * m_idx));
                    m_idx++;
                    if (m_idx == 8) begin
                        m_idx = 0;
                        void'(m_words.pop_front());
                    end
                end else begin
                    m_unf = 1'b1;
                end
                byte_q.push_back(b);
            end
            if (vld && rdy) begin
                m_words.push_back(dat);
                acc = 1;
            end
            r.vs   = m_run && (m_p < VSC);
            r.href = act;
            r.sof  = act && l == 0 && c == 0;
            r.eof  = act && c == HA - 1;
        end
        r.unf = m_unf;
        r.cf  = m_cf;
        r.ch  = m_ch;
        r.rdy = (m_words.size() < 2);
        ctl_q.push_back(r);
    endtask

    task automatic cyc();
        bit acc;
        @(posedge clk);
        model_step(reset, enable, valid, data, acc);
        #1;
        if (acc) begin
            wcnt++;
            data = seq ? seqword(wcnt) : {$urandom, $urandom};
        end
    endtask

    task automatic wait_pos(input int cf, input int p, input string nm);
        int n;
        n = 0;
        while (!(m_run && int'(m_cf) == cf && m_p == p) && n < 2000) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL wait_%s timeout got cf=%0d p=%0d want cf=%0d p=%0d",
                     nm, m_cf, m_p, cf, p);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (m_run && n < 2000) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL idle_%s timeout got running want idle", nm);
        end
    endtask

    always @(negedge clk) begin : mon
        ctl_t       e;
        ctl_t       g;
        logic [7:0] eb;
        if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            g = {VSYNC, HREF, SOF, EOF, underflow, ready_ddr,
                 count_frame, count_href};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL ctl t=%0t got vs%b hr%b sof%b eof%b unf%b rdy%b cf%0d ch%0d want vs%b hr%b sof%b eof%b unf%b rdy%b cf%0d ch%0d",
                         $time, g.vs, g.href, g.sof, g.eof, g.unf, g.rdy,
                         g.cf, g.ch, e.vs, e.href, e.sof, e.eof, e.unf,
                         e.rdy, e.cf, e.ch);
            end
            checks++;
            if (HREF === 1'b1) begin
                if (byte_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte t=%0t got D=%h want none queued",
                             $time, D);
                end else begin
                    eb = byte_q.pop_front();
                    if (D !== eb) begin
                        errors++;
                        $display("FAIL byte t=%0t got %h want %h",
                                 $time, D, eb);
                    end
                end
            end else if (D !== 8'h00) begin
                errors++;
                $display("FAIL d_idle t=%0t got %h want 00", $time, D);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        valid  = 1'b0;
        data   = seqword(0);
        repeat (3) cyc();
        reset = 1'b0;
        repeat (2) cyc();

        // Continuous source, one full frame, enable dropped in line 1.
        valid  = 1'b1;
        enable = 1'b1;
        wait_pos(1, VSC + VBPC + LN + 3, "line1");
        enable = 1'b0;
        wait_idle("a");
        repeat (20) cyc();

        // Starved start of frame after a flush.
        reset = 1'b1;
        cyc();
        reset  = 1'b0;
        valid  = 1'b0;
        enable = 1'b1;
        repeat (25) cyc();
        valid = 1'b1;
        wait_pos(2, VSC + VBPC + 2, "frame2");
        enable = 1'b0;
        wait_idle("b");
        repeat (5) cyc();

        // Reset at byte 5 of line 0, then restart.
        enable = 1'b1;
        wait_pos(3, VSC + VBPC + 5, "byte5");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_pos(1, VSC + VBPC + LN + 2, "restart");
        enable = 1'b0;
        wait_idle("c");

        // Random source, enable toggles and rare resets.
        seq = 0;
        data = {$urandom, $urandom};
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0)
                enable = ~enable;
            reset = ($urandom_range(0, 599) == 0);
            cyc();
        end
        reset = 1'b0;

        // Long run to wrap the frame counter.
        seq = 1;
        valid = 1'b1;
        enable = 1'b1;
        repeat (258 * FL) cyc();
        enable = 1'b0;
        wait_idle("e");
        repeat (5) cyc();

        @(negedge clk);
        #1;
        checks++;
        if (byte_q.size() != 0 || ctl_q.size() != 0) begin
            errors++;
            $display("FAIL drain got bytes=%0d ctl=%0d want 0 0",
                     byte_q.size(), ctl_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
